// File: rtl/wrap_mon_pkg.sv
// Shared types and helpers for the counter wrap monitor: event kinds, the
// event record layout and FIFO pointer sizing.
package wrap_mon_pkg;

   typedef enum logic [1:0] {
      EVT_NONE    = 2'd0,
      EVT_WRAP_UP = 2'd1,
      EVT_WRAP_DN = 2'd2,
      EVT_PRESET  = 2'd3
   } evt_kind_t;

   localparam int unsigned DEF_STAMP_W = 8;

   // Record layout at the default stamp width; the top re-declares it at its STAMP_W.
   typedef struct packed {
      evt_kind_t              kind;
      logic [DEF_STAMP_W-1:0] stamp;
   } evt_rec_t;

   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wrap_mon_fifo.sv
// Synchronous event FIFO with a registered head output; head holds its last
// value while empty.
module wrap_mon_fifo
   import wrap_mon_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] dout_q;
   logic              do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr_nxt  = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
   assign rd_nxt  = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
   assign dout    = dout_q;

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Head register loads the pushed record when it becomes the new head,
   // otherwise the entry behind the one being popped.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_nxt;
         if (do_pop)  rd_ptr <= rd_nxt;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (do_push && (empty || (count == CNT_W'(1) && do_pop)))
            dout_q <= din;
         else if (do_pop && count >= CNT_W'(2))
            dout_q <= mem[rd_nxt];
      end
   end

endmodule

// File: rtl/count_wrap_monitor.sv
// Watches a WIDTH-bit up/down preset counter, queues timestamped wrap events
// and keeps a saturating wrap tally. Define COUNT_WRAP_MONITOR_PRESET_EVT_EN
// to also queue preset loads as EVT_PRESET records.
module count_wrap_monitor
   import wrap_mon_pkg::*;
#(
   parameter int unsigned WIDTH   = 2,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned STAMP_W = 8,
   parameter int unsigned WCNT_W  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [WIDTH-1:0]   counter,
   input  logic               updown,
   input  logic               preset,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [1:0]         evt_kind,
   output logic [STAMP_W-1:0] evt_stamp,
   output logic [WCNT_W-1:0]  wrap_count,
   output logic               overflow
);

   typedef struct packed {
      evt_kind_t          kind;
      logic [STAMP_W-1:0] stamp;
   } rec_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]   prev_cnt;
   logic               dir_d, pre_d, prev_ok;
   logic [STAMP_W-1:0] stamp;
   logic [WCNT_W-1:0]  wrap_q;
   logic               ovf_q;
   evt_kind_t          det_kind;
   logic               is_wrap, push_req, pop, full, empty;
   rec_t               rec_in, rec_out;

   always_comb begin
      det_kind = EVT_NONE;
      if (prev_ok) begin
         if (pre_d)
            det_kind = EVT_PRESET;
         else if (dir_d && prev_cnt == CNT_MAX && counter == '0)
            det_kind = EVT_WRAP_UP;
         else if (!dir_d && prev_cnt == '0 && counter == CNT_MAX)
            det_kind = EVT_WRAP_DN;
      end
   end

   assign is_wrap = (det_kind == EVT_WRAP_UP) || (det_kind == EVT_WRAP_DN);
`ifdef COUNT_WRAP_MONITOR_PRESET_EVT_EN
   assign push_req = (det_kind != EVT_NONE);
`else
   assign push_req = is_wrap;
`endif

   assign evt_valid    = !empty;
   assign pop          = evt_valid && evt_ready;
   assign rec_in.kind  = det_kind;
   assign rec_in.stamp = stamp;
   assign evt_kind     = rec_out.kind;
   assign evt_stamp    = rec_out.stamp;
   assign wrap_count   = wrap_q;
   assign overflow     = ovf_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_cnt <= '0;
         dir_d    <= 1'b0;
         pre_d    <= 1'b0;
         prev_ok  <= 1'b0;
         stamp    <= '0;
         wrap_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         prev_cnt <= counter;
         dir_d    <= updown;
         pre_d    <= preset;
         prev_ok  <= 1'b1;
         stamp    <= stamp + STAMP_W'(1);
         if (is_wrap && wrap_q != '1) wrap_q <= wrap_q + WCNT_W'(1);
         if (push_req && full && !pop) ovf_q <= 1'b1;
      end
   end

   wrap_mon_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W ($bits(rec_t))
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .pop   (pop),
      .din   (rec_in),
      .dout  (rec_out),
      .full  (full),
      .empty (empty)
   );

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed self-checking bench for count_wrap_monitor; a second instance with
// WCNT_W=2 checks tally saturation.
module tb_count_wrap_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] counter;
   logic       updown, preset, evt_ready;
   logic       evt_valid, overflow;
   logic [1:0] evt_kind;
   logic [7:0] evt_stamp, wrap_count;
   logic       s_valid, s_overflow;
   logic [1:0] s_kind, s_wcnt;
   logic [7:0] s_stamp;

   int tests_run    = 0;
   int tests_failed = 0;
   int since_rst    = 0;

   always #5 clk = ~clk;

   count_wrap_monitor #(.WIDTH(2), .DEPTH(4), .STAMP_W(8), .WCNT_W(8)) dut (
      .clock(clk), .reset(reset), .counter(counter), .updown(updown), .preset(preset),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_kind(evt_kind),
      .evt_stamp(evt_stamp), .wrap_count(wrap_count), .overflow(overflow));

   count_wrap_monitor #(.WIDTH(2), .DEPTH(4), .STAMP_W(8), .WCNT_W(2)) u_sat (
      .clock(clk), .reset(reset), .counter(counter), .updown(updown), .preset(preset),
      .evt_valid(s_valid), .evt_ready(evt_ready), .evt_kind(s_kind),
      .evt_stamp(s_stamp), .wrap_count(s_wcnt), .overflow(s_overflow));

   // One cycle of stimulus; outputs are sampled 1ns after the edge.
   task automatic drive(input logic [1:0] c, input logic ud, input logic pr);
      counter = c; updown = ud; preset = pr;
      @(posedge clk); #1;
      since_rst++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      since_rst = 0;
   endtask

   task automatic test_reset();
      evt_ready = 1'b1; counter = 2'd2; updown = 1'b1; preset = 1'b0;
      do_reset();
      tests_run++;
      if (evt_valid !== 1'b0 || evt_kind !== 2'd0 || evt_stamp !== 8'd0 ||
          wrap_count !== 8'd0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset: valid=%b kind=%0d stamp=%0d wcnt=%0d ovf=%b, want 0 0 0 0 0",
                  evt_valid, evt_kind, evt_stamp, wrap_count, overflow);
      end
   endtask

   task automatic test_first_cycle();
      evt_ready = 1'b1; counter = 2'd3; updown = 1'b1; preset = 1'b0;
      do_reset();
      drive(2'd0, 1'b1, 1'b0);
      drive(2'd1, 1'b1, 1'b0);
      tests_run++;
      if (evt_valid !== 1'b0 || wrap_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL first_cycle: valid=%b wcnt=%0d, want 0 0", evt_valid, wrap_count);
      end
   endtask

   task automatic test_wrap_up();
      logic [1:0] seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
      evt_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(seq[i], 1'b1, 1'b0);
         tests_run++;
         if (evt_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_up_idle[%0d]: valid=%b want 0", i, evt_valid);
         end
      end
      drive(2'd0, 1'b1, 1'b0);
      tests_run++;
      if (evt_valid !== 1'b1 || evt_kind !== 2'd1 || evt_stamp !== 8'd4 || wrap_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL wrap_up: valid=%b kind=%0d stamp=%0d wcnt=%0d, want 1 1 4 1",
                  evt_valid, evt_kind, evt_stamp, wrap_count);
      end
      drive(2'd1, 1'b1, 1'b0);
      tests_run++;
      if (evt_valid !== 1'b0 || evt_stamp !== 8'd4 || wrap_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL wrap_up_pop: valid=%b stamp=%0d wcnt=%0d, want 0 4 1",
                  evt_valid, evt_stamp, wrap_count);
      end
   endtask

   task automatic test_wrap_dn_reset();
      evt_ready = 1'b0;
      do_reset();
      drive(2'd1, 1'b0, 1'b0);
      drive(2'd0, 1'b0, 1'b0);
      drive(2'd3, 1'b0, 1'b0);
      tests_run++;
      if (evt_valid !== 1'b1 || evt_kind !== 2'd2 || evt_stamp !== 8'd2 || wrap_count !== 8'd1) begin
         tests_failed++;
         $display("FAIL wrap_dn: valid=%b kind=%0d stamp=%0d wcnt=%0d, want 1 2 2 1",
                  evt_valid, evt_kind, evt_stamp, wrap_count);
      end
      do_reset();
      tests_run++;
      if (evt_valid !== 1'b0 || wrap_count !== 8'd0 || evt_kind !== 2'd0 || evt_stamp !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_mid: valid=%b wcnt=%0d kind=%0d stamp=%0d, want 0 0 0 0",
                  evt_valid, wrap_count, evt_kind, evt_stamp);
      end
   endtask

   task automatic test_preset();
      evt_ready = 1'b0;
      do_reset();
      drive(2'd2, 1'b1, 1'b0);
      drive(2'd3, 1'b1, 1'b1);
      drive(2'd0, 1'b1, 1'b0);
      tests_run++;
`ifdef COUNT_WRAP_MONITOR_PRESET_EVT_EN
      if (evt_valid !== 1'b1 || evt_kind !== 2'd3 || evt_stamp !== 8'd2 || wrap_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL preset: valid=%b kind=%0d stamp=%0d wcnt=%0d, want 1 3 2 0",
                  evt_valid, evt_kind, evt_stamp, wrap_count);
      end
`else
      if (evt_valid !== 1'b0 || wrap_count !== 8'd0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL preset: valid=%b wcnt=%0d ovf=%b, want 0 0 0",
                  evt_valid, wrap_count, overflow);
      end
`endif
   endtask

   task automatic test_full_pop_push();
      logic [7:0] exp [4] = '{8'd4, 8'd6, 8'd8, 8'd10};
      evt_ready = 1'b0;
      do_reset();
      drive(2'd0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         drive(2'd3, 1'b1, 1'b0);
         drive(2'd0, 1'b1, 1'b0);
      end
      tests_run++;
      if (evt_valid !== 1'b1 || evt_stamp !== 8'd2 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_fill: valid=%b stamp=%0d ovf=%b, want 1 2 0", evt_valid, evt_stamp, overflow);
      end
      drive(2'd3, 1'b1, 1'b0);
      evt_ready = 1'b1;
      drive(2'd0, 1'b1, 1'b0);
      evt_ready = 1'b0;
      tests_run++;
      if (evt_valid !== 1'b1 || evt_stamp !== 8'd4 || overflow !== 1'b0 || wrap_count !== 8'd5) begin
         tests_failed++;
         $display("FAIL full_pop_push: valid=%b stamp=%0d ovf=%b wcnt=%0d, want 1 4 0 5",
                  evt_valid, evt_stamp, overflow, wrap_count);
      end
      drive(2'd1, 1'b1, 1'b0);
      tests_run++;
      if (evt_stamp !== 8'd4 || evt_kind !== 2'd1) begin
         tests_failed++;
         $display("FAIL hold_stable: stamp=%0d kind=%0d, want 4 1", evt_stamp, evt_kind);
      end
      evt_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tests_run++;
         if (evt_valid !== 1'b1 || evt_stamp !== exp[j] || evt_kind !== 2'd1) begin
            tests_failed++;
            $display("FAIL full_drain[%0d]: valid=%b stamp=%0d kind=%0d, want 1 %0d 1",
                     j, evt_valid, evt_stamp, evt_kind, exp[j]);
         end
         drive(2'd1, 1'b1, 1'b0);
      end
      tests_run++;
      if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_empty: valid=%b ovf=%b, want 0 0", evt_valid, overflow);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
      evt_ready = 1'b0;
      do_reset();
      drive(2'd0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         drive(2'd3, 1'b1, 1'b0);
         drive(2'd0, 1'b1, 1'b0);
         tests_run++;
         if (overflow !== (k == 4) || evt_stamp !== 8'd2) begin
            tests_failed++;
            $display("FAIL ovf_fill[%0d]: ovf=%b stamp=%0d, want %0d 2", k, overflow, evt_stamp, (k == 4));
         end
      end
      tests_run++;
      if (wrap_count !== 8'd5 || s_wcnt !== 2'd3) begin
         tests_failed++;
         $display("FAIL wrap_sat: wcnt=%0d sat_wcnt=%0d, want 5 3", wrap_count, s_wcnt);
      end
      evt_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         tests_run++;
         if (evt_valid !== 1'b1 || evt_stamp !== exp[j]) begin
            tests_failed++;
            $display("FAIL ovf_drain[%0d]: valid=%b stamp=%0d, want 1 %0d", j, evt_valid, evt_stamp, exp[j]);
         end
         drive(2'd1, 1'b1, 1'b0);
      end
      tests_run++;
      if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_sticky: valid=%b ovf=%b, want 0 1", evt_valid, overflow);
      end
   endtask

   initial begin
      reset = 1'b1; counter = 2'd0; updown = 1'b1; preset = 1'b0; evt_ready = 1'b0;
      test_reset();
      test_first_cycle();
      test_wrap_up();
      test_wrap_dn_reset();
      test_preset();
      test_full_pop_push();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
